// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative array multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width helper: at least one bit even when only one step is needed.
  function automatic int clog2(input int value);
    int result;
    if (value > 2) begin
      result = $clog2(value);
    end else begin
      result = 1;
    end
    return result;
  endfunction

  // Legal parameter combination: WIDTH >= 2 and ROWS dividing WIDTH.
  function automatic bit params_ok(input int width, input int rows);
    bit ok;
    if (rows < 1 || width < 2) begin
      ok = 1'b0;
    end else begin
      ok = ((width % rows) == 0);
    end
    return ok;
  endfunction

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic cin);
    return x ^ y ^ cin;
  endfunction

  // Full-adder carry bit.
  function automatic logic fa_carry(input logic x, input logic y, input logic cin);
    return (x & y) | (cin & (x ^ y));
  endfunction

endpackage

// File: rtl/pp_row_add.sv
// One partial-product row: acc + ((mbit ? ma : 0) << shift), as a ripple
// chain of adder cells over the full 2*WIDTH product width.
module pp_row_add
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   ma,
  input  logic               mbit,
  input  logic [SW-1:0]      shift,
  output logic [2*WIDTH-1:0] sum
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] addend_s;
  logic [PW-1:0] carry_s;

  assign addend_s   = PW'(ma & {WIDTH{mbit}}) << shift;
  assign carry_s[0] = 1'b0;

  // Carry out of the top bit is dropped: the product always fits in 2*WIDTH.
  for (genvar k = 0; k < PW; k++) begin : g_bit
    assign sum[k] = fa_sum(acc[k], addend_s[k], carry_s[k]);
    if (k < PW - 1) begin : g_carry
      assign carry_s[k+1] = fa_carry(acc[k], addend_s[k], carry_s[k]);
    end
  end

endmodule

// File: rtl/iter_array_mul.sv
// Iterative array multiplier: ROWS partial-product rows are accumulated per
// clock on operand magnitudes; the sign is applied on the final step.
module iter_array_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROWS  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z
);

  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = WIDTH / ROWS;
  localparam int CW    = clog2(STEPS);
  localparam int SW    = clog2(WIDTH);

  if (!params_ok(WIDTH, ROWS)) begin : g_param_check
    $fatal(1, "iter_array_mul: WIDTH must be >= 2 and a multiple of ROWS");
  end

  state_t           state_r, state_s;
  logic [WIDTH-1:0] ma_r, mb_r;
  logic             neg_r;
  logic [PW-1:0]    acc_r;
  logic [CW-1:0]    cnt_r;
  logic             out_valid_r;

  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [PW-1:0]    chain_s [ROWS+1];
  logic [SW-1:0]    shift_s [ROWS];
  logic [PW-1:0]    sum_s, neg_sum_s;

  // in_ready is masked by rst_n so it reads low while reset is asserted.
  assign in_ready  = rst_n & (state_r == IDLE);
  assign accept_s  = in_valid & in_ready;
  assign last_s    = (state_r == BUSY) && (cnt_r == CW'(STEPS - 1));
  assign out_valid = out_valid_r;
  assign z         = acc_r;

  // Magnitudes; |-2^(W-1)| wraps to 2^(W-1), which is correct as unsigned.
  assign a_mag_s = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag_s = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  assign chain_s[0] = acc_r;
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    assign shift_s[i] = SW'(int'(cnt_r) * ROWS + i);
    pp_row_add #(
      .WIDTH (WIDTH),
      .SW    (SW)
    ) u_row (
      .acc   (chain_s[i]),
      .ma    (ma_r),
      .mbit  (mb_r[shift_s[i]]),
      .shift (shift_s[i]),
      .sum   (chain_s[i+1])
    );
  end

  assign sum_s     = chain_s[ROWS];
  assign neg_sum_s = ~sum_s + PW'(1);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered out_valid (high exactly in DONE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture, row accumulation and final sign application.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ma_r  <= '0;
      mb_r  <= '0;
      neg_r <= 1'b0;
      acc_r <= '0;
      cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            ma_r  <= a_mag_s;
            mb_r  <= b_mag_s;
            neg_r <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_r <= '0;
            cnt_r <= '0;
          end else begin
            acc_r <= acc_r;
          end
        end
        BUSY: begin
          if (last_s) begin
            acc_r <= neg_r ? neg_sum_s : sum_s;
            cnt_r <= '0;
          end else begin
            acc_r <= sum_s;
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= '0;
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
